// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register and write-back stage: load extract/extend, result select,
// register-file write port, ID-stage write-to-read bypass selects and a retired-write counter.
module mem_wb_writeback #(
   parameter int unsigned BIG_ENDIAN = 1,
   parameter int unsigned CNT_W      = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Stall_WB,
   input  logic             Flush_MEM,
   input  logic             RegWrite_MEM,
   input  logic             MemtoReg_MEM,
   input  logic [2:0]       Load_Type_MEM,
   input  logic [1:0]       Addr_Low_MEM,
   input  logic [31:0]      ALU_Result_MEM,
   input  logic [31:0]      Mem_Read_Data_MEM,
   input  logic [4:0]       Write_Register_MEM,
   input  logic [4:0]       Read_Address_1_ID,
   input  logic [4:0]       Read_Address_2_ID,
   output logic             RegWrite_WB,
   output logic [4:0]       Write_Register_WB,
   output logic [31:0]      Write_Data_WB,
   output logic [1:0]       ID_Register_Write_to_Read,
   output logic [CNT_W-1:0] Retired_Count
);

   localparam logic [2:0] LdLb  = 3'b001;
   localparam logic [2:0] LdLbu = 3'b010;
   localparam logic [2:0] LdLh  = 3'b011;
   localparam logic [2:0] LdLhu = 3'b100;

   logic             regwrite_q, regwrite_d;
   logic             memtoreg_q, memtoreg_d;
   logic [2:0]       load_type_q, load_type_d;
   logic [1:0]       addr_low_q, addr_low_d;
   logic [31:0]      alu_q, alu_d;
   logic [31:0]      mem_q, mem_d;
   logic [4:0]       wreg_q, wreg_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic       retire;
   logic [1:0] byte_idx;
   logic [7:0] byte_v;
   logic       half_hi;
   logic [15:0] half_v;
   logic [31:0] load_data;

   // Flush takes priority over stall: a flushed slot is a bubble even if WB is held.
   always_comb begin
      regwrite_d  = regwrite_q;
      memtoreg_d  = memtoreg_q;
      load_type_d = load_type_q;
      addr_low_d  = addr_low_q;
      alu_d       = alu_q;
      mem_d       = mem_q;
      wreg_d      = wreg_q;
      if (Flush_MEM) begin
         regwrite_d  = 1'b0;
         memtoreg_d  = 1'b0;
         load_type_d = 3'b000;
         addr_low_d  = 2'b00;
         alu_d       = 32'h0;
         mem_d       = 32'h0;
         wreg_d      = 5'd0;
      end else if (!Stall_WB) begin
         regwrite_d  = RegWrite_MEM;
         memtoreg_d  = MemtoReg_MEM;
         load_type_d = Load_Type_MEM;
         addr_low_d  = Addr_Low_MEM;
         alu_d       = ALU_Result_MEM;
         mem_d       = Mem_Read_Data_MEM;
         wreg_d      = Write_Register_MEM;
      end
   end

   // A held slot only retires on the edge where the stage finally advances.
   always_comb begin
      retire = regwrite_q & (wreg_q != 5'd0) & (~Stall_WB | Flush_MEM);
      cnt_d  = cnt_q;
      if (retire && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         regwrite_q  <= 1'b0;
         memtoreg_q  <= 1'b0;
         load_type_q <= 3'b000;
         addr_low_q  <= 2'b00;
         alu_q       <= 32'h0;
         mem_q       <= 32'h0;
         wreg_q      <= 5'd0;
         cnt_q       <= '0;
      end else begin
         regwrite_q  <= regwrite_d;
         memtoreg_q  <= memtoreg_d;
         load_type_q <= load_type_d;
         addr_low_q  <= addr_low_d;
         alu_q       <= alu_d;
         mem_q       <= mem_d;
         wreg_q      <= wreg_d;
         cnt_q       <= cnt_d;
      end
   end

   // byte_idx is the little-endian lane number of the addressed byte.
   always_comb begin
      byte_idx = (BIG_ENDIAN != 0) ? (2'd3 - addr_low_q) : addr_low_q;
      byte_v   = mem_q[{byte_idx, 3'b000} +: 8];
      half_hi  = (BIG_ENDIAN != 0) ? ~addr_low_q[1] : addr_low_q[1];
      half_v   = half_hi ? mem_q[31:16] : mem_q[15:0];
      case (load_type_q)
         LdLb:    load_data = {{24{byte_v[7]}}, byte_v};
         LdLbu:   load_data = {24'h0, byte_v};
         LdLh:    load_data = {{16{half_v[15]}}, half_v};
         LdLhu:   load_data = {16'h0, half_v};
         default: load_data = mem_q;
      endcase
   end

   always_comb begin
      RegWrite_WB                  = regwrite_q;
      Write_Register_WB            = wreg_q;
      Write_Data_WB                = memtoreg_q ? load_data : alu_q;
      ID_Register_Write_to_Read[0] = regwrite_q & (wreg_q != 5'd0) & (wreg_q == Read_Address_1_ID);
      ID_Register_Write_to_Read[1] = regwrite_q & (wreg_q != 5'd0) & (wreg_q == Read_Address_2_ID);
      Retired_Count                = cnt_q;
   end

endmodule
